// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier / dot-product datapath.
//
// Contents:
//   acc_state_t : accumulator FSM state (ACCUM while collecting terms,
//                 DONE while holding a finished result)
//   PROD_W      : width of one multiplier product (4x4 unsigned -> 8 bits)
//   DEF_ACC_W   : default accumulator width (16 x 225 = 3600 fits in 12 bits)
package mult_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } acc_state_t;

  localparam int PROD_W    = 8;
  localparam int DEF_ACC_W = 12;

endpackage

// File: rtl/dot_product_accumulator_sat_adder.sv
// Combinational saturating adder used by the dot-product accumulator.
//
// Ports:
//   a         in  A_W  running accumulator value
//   b         in  B_W  unsigned term, zero-extended to A_W+1 before the add
//   sticky_in in  1    saturation already happened earlier in this group
//   sum       out A_W  a + b, or all-ones when saturated
//   sat       out 1    result is saturated (carry out of A_W bits, or sticky)
module sat_adder #(
  parameter int A_W = 12,
  parameter int B_W = 8
) (
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  input  logic           sticky_in,
  output logic [A_W-1:0] sum,
  output logic           sat
);

  logic [A_W:0] wide_sum;

  // One extra bit catches the carry out of the accumulator width.
  assign wide_sum = {1'b0, a} + (A_W + 1)'(b);

  // Once saturated, later small terms must not make the sum look valid again.
  assign sat = wide_sum[A_W] | sticky_in;
  assign sum = sat ? {A_W{1'b1}} : wide_sum[A_W-1:0];

endmodule

// File: rtl/dot_product_accumulator.sv
// Dot-product accumulator: sums a group of unsigned products arriving on a
// valid/ready stream and presents one result per group on a valid/ready
// output. A group closes on in_last or after MAX_TERMS terms.
//
// Ports:
//   clk        in  1      rising-edge clock
//   rst_n      in  1      synchronous active-low reset
//   p_in       in  P_W    unsigned product term
//   in_valid   in  1      p_in valid this cycle
//   in_last    in  1      p_in is the final term of the group
//   in_ready   out 1      block accepts p_in (decoded from state only)
//   sum_out    out ACC_W  accumulated (possibly saturated) group result
//   term_count out CNT_W  number of terms in the result
//   overflow   out 1      the result saturated
//   out_valid  out 1      result outputs are valid
//   out_ready  in  1      consumer takes the result
module dot_product_accumulator
  import mult_pkg::*;
#(
  parameter int P_W       = PROD_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int MAX_TERMS = 16,
  parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [P_W-1:0]   p_in,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [ACC_W-1:0] sum_out,
  output logic [CNT_W-1:0] term_count,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  acc_state_t       state_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] acc_next;
  logic             ovf_reg;
  logic             ovf_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             accept;
  logic             final_term;

  sat_adder #(
    .A_W(ACC_W),
    .B_W(P_W)
  ) u_sat_adder (
    .a        (acc_reg),
    .b        (p_in),
    .sticky_in(ovf_reg),
    .sum      (acc_next),
    .sat      (ovf_next)
  );

  // Ready depends only on state so there is no in_valid -> in_ready path.
  assign in_ready   = (state_reg == ACCUM);
  assign accept     = in_valid & in_ready;
  assign cnt_next   = cnt_reg + CNT_W'(1);
  assign final_term = in_last | (cnt_reg == CNT_W'(MAX_TERMS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= ACCUM;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      ovf_reg    <= 1'b0;
      out_valid  <= 1'b0;
      sum_out    <= '0;
      term_count <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state_reg)
        ACCUM: begin
          if (accept) begin
            acc_reg <= acc_next;
            ovf_reg <= ovf_next;
            cnt_reg <= cnt_next;
            if (final_term) begin
              // Result registers load the post-add values on the same edge.
              sum_out    <= acc_next;
              term_count <= cnt_next;
              overflow   <= ovf_next;
              out_valid  <= 1'b1;
              state_reg  <= DONE;
            end
          end
        end
        DONE: begin
          // Result outputs keep their value; only out_valid drops.
          if (out_ready) begin
            out_valid <= 1'b0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
            state_reg <= ACCUM;
          end
        end
        default: state_reg <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_accumulator.sv
module tb_dot_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  p_in;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;

  logic        in_ready;
  logic [11:0] sum_out;
  logic [4:0]  term_count;
  logic        overflow;
  logic        out_valid;

  logic        in_ready9;
  logic [8:0]  sum_out9;
  logic [4:0]  term_count9;
  logic        overflow9;
  logic        out_valid9;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dot_product_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p_in      (p_in),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .sum_out   (sum_out),
    .term_count(term_count),
    .overflow  (overflow),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Narrow instance fed the same stream to exercise saturation.
  dot_product_accumulator #(.ACC_W(9)) dut9 (
    .clk       (clk),
    .rst_n     (rst_n),
    .p_in      (p_in),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready9),
    .sum_out   (sum_out9),
    .term_count(term_count9),
    .overflow  (overflow9),
    .out_valid (out_valid9),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [7:0] p;
    bit         last;
    bit         chk;
    int         sum12;
    int         cnt;
    bit         ovf12;
    int         sum9;
    bit         ovf9;
  } beat_t;

  beat_t vecs[15];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send(input logic [7:0] p, input bit last);
    int waitc = 0;
    p_in = p;
    in_valid = 1'b1;
    in_last = last;
    while (!in_ready && waitc < 40) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({name, "_ready_back"}, 32'(in_ready), 32'd1);
    $display("handshake %s: out_valid=%0d in_ready=%0d", name, out_valid, in_ready);
  endtask

  initial begin
    vecs[0]  = '{8'd6,   0, 0, 0,   0, 0, 0,   0};
    vecs[1]  = '{8'd15,  0, 0, 0,   0, 0, 0,   0};
    vecs[2]  = '{8'd225, 1, 1, 246, 3, 0, 246, 0};
    vecs[3]  = '{8'd0,   1, 1, 0,   1, 0, 0,   0};
    vecs[4]  = '{8'd200, 0, 0, 0,   0, 0, 0,   0};
    vecs[5]  = '{8'd200, 0, 0, 0,   0, 0, 0,   0};
    vecs[6]  = '{8'd200, 1, 1, 600, 3, 0, 511, 1};
    vecs[7]  = '{8'd10,  1, 1, 10,  1, 0, 10,  0};
    vecs[8]  = '{8'd255, 0, 0, 0,   0, 0, 0,   0};
    vecs[9]  = '{8'd255, 0, 0, 0,   0, 0, 0,   0};
    vecs[10] = '{8'd1,   1, 1, 511, 3, 0, 511, 0};
    vecs[11] = '{8'd255, 0, 0, 0,   0, 0, 0,   0};
    vecs[12] = '{8'd255, 0, 0, 0,   0, 0, 0,   0};
    vecs[13] = '{8'd2,   0, 0, 0,   0, 0, 0,   0};
    vecs[14] = '{8'd0,   1, 1, 512, 4, 0, 511, 1};

    rst_n = 1'b0;
    p_in = '0;
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum_out), 32'd0);
    check("rst_count", 32'(term_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    $display("reset: in_ready=%0d out_valid=%0d sum=%0d", in_ready, out_valid, sum_out);

    // Table-driven groups: result checked the cycle after the final beat.
    for (int i = 0; i < 15; i++) begin
      send(vecs[i].p, vecs[i].last);
      if (vecs[i].chk) begin
        check("tbl_valid", 32'(out_valid), 32'd1);
        check("tbl_in_ready", 32'(in_ready), 32'd0);
        check("tbl_sum", 32'(sum_out), 32'(vecs[i].sum12));
        check("tbl_count", 32'(term_count), 32'(vecs[i].cnt));
        check("tbl_ovf", 32'(overflow), 32'(vecs[i].ovf12));
        check("tbl_valid9", 32'(out_valid9), 32'd1);
        check("tbl_sum9", 32'(sum_out9), 32'(vecs[i].sum9));
        check("tbl_count9", 32'(term_count9), 32'(vecs[i].cnt));
        check("tbl_ovf9", 32'(overflow9), 32'(vecs[i].ovf9));
        $display("group end vec %0d: sum=%0d cnt=%0d ovf=%0d | sum9=%0d ovf9=%0d",
                 i, sum_out, term_count, overflow, sum_out9, overflow9);
        handshake("tbl");
        check("tbl_sum_kept", 32'(sum_out), 32'(vecs[i].sum12));
      end
    end

    // Auto-close at MAX_TERMS, then back-pressure a 17th beat while held.
    for (int i = 0; i < 16; i++) send(8'd225, 1'b0);
    check("auto_valid", 32'(out_valid), 32'd1);
    check("auto_sum", 32'(sum_out), 32'd3600);
    check("auto_count", 32'(term_count), 32'd16);
    check("auto_ovf", 32'(overflow), 32'd0);
    check("auto_sum9", 32'(sum_out9), 32'd511);
    check("auto_ovf9", 32'(overflow9), 32'd1);
    $display("auto-close: sum=%0d cnt=%0d ovf=%0d", sum_out, term_count, overflow);
    p_in = 8'd5;
    in_valid = 1'b1;
    in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_sum", 32'(sum_out), 32'd3600);
      check("hold_count", 32'(term_count), 32'd16);
      $display("hold cycle %0d: in_ready=%0d out_valid=%0d sum=%0d", i, in_ready, out_valid, sum_out);
    end
    handshake("auto");
    // in_valid still high with p=5: accepted on this coming edge.
    @(negedge clk);
    send(8'd7, 1'b1);
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_sum", 32'(sum_out), 32'd12);
    check("stall_count", 32'(term_count), 32'd2);
    $display("stalled beat group: sum=%0d cnt=%0d", sum_out, term_count);
    handshake("stall");

    // Reset mid-group after two accepted beats.
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_sum", 32'(sum_out), 32'd0);
    check("midrst_count", 32'(term_count), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    $display("mid-group reset: out_valid=%0d sum=%0d cnt=%0d", out_valid, sum_out, term_count);

    // Reset while holding a result.
    send(8'd4, 1'b1);
    check("donerst_pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("donerst_valid", 32'(out_valid), 32'd0);
    check("donerst_sum", 32'(sum_out), 32'd0);
    check("donerst_count", 32'(term_count), 32'd0);
    check("donerst_in_ready", 32'(in_ready), 32'd1);
    $display("done-state reset: out_valid=%0d sum=%0d cnt=%0d", out_valid, sum_out, term_count);

    send(8'd9, 1'b0);
    send(8'd9, 1'b1);
    check("post_rst_sum", 32'(sum_out), 32'd18);
    check("post_rst_count", 32'(term_count), 32'd2);
    check("post_rst_valid", 32'(out_valid), 32'd1);
    $display("post-reset group: sum=%0d cnt=%0d", sum_out, term_count);
    handshake("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
